// File: rtl/riscv_multicycle_control.sv
// riscv_multicycle_control: main control FSM for the multi-cycle RV32I core.
// Sequences fetch/decode/execute/memory/write-back and drives the datapath.
// Ports:
//   clk, reset             - core clock, synchronous active-high reset
//   opcode, func3          - instruction fields from IR (valid from DECODE on)
//   alu_zero, mem_ready    - ALU zero flag, memory completion strobe
//   mem_req/mem_we/mem_addr_sel - unified memory request handshake
//   ir_we, pc_we, pc_src   - IR/PC load controls
//   alu_src_a/alu_src_b/ALUOp/alu_func7_en - ALU operand and op selection
//   reg_we, wb_sel         - register file write-back control
//   illegal                - sticky illegal-instruction flag
module riscv_multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] ALUOp,
    output logic       alu_func7_en,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    // Moore (state-only) outputs, kept in a register alongside the state
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       alu_func7_en;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       illegal;
    } moore_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    state_e state_q, state_d;
    moore_t moore_q, moore_d;

    // Output decode for a given state; func3 only matters for EXEC_I
    function automatic moore_t decode_outputs(input state_e s, input logic [2:0] f3);
        moore_t o;
        o = '0;
        case (s)
            S_FETCH: begin
                o.mem_req   = 1'b1;
                o.alu_src_b = 2'd2;
                o.alu_op    = 2'b10;
            end
            S_DECODE: begin
                o.alu_src_a = 2'd2;
                o.alu_src_b = 2'd1;
                o.alu_op    = 2'b10;
            end
            S_EXEC_R: begin
                o.alu_src_a    = 2'd1;
                o.alu_func7_en = 1'b1;
            end
            S_EXEC_I: begin
                o.alu_src_a    = 2'd1;
                o.alu_src_b    = 2'd1;
                // only SRLI/SRAI carry a meaningful func7 bit
                o.alu_func7_en = (f3 == 3'b101);
            end
            S_ALU_WB: begin
                o.reg_we = 1'b1;
            end
            S_MEM_ADDR: begin
                o.alu_src_a = 2'd1;
                o.alu_src_b = 2'd1;
                o.alu_op    = 2'b10;
            end
            S_MEM_RD: begin
                o.mem_req      = 1'b1;
                o.mem_addr_sel = 1'b1;
            end
            S_MEM_WB: begin
                o.reg_we = 1'b1;
                o.wb_sel = 2'd1;
            end
            S_MEM_WR: begin
                o.mem_req      = 1'b1;
                o.mem_we       = 1'b1;
                o.mem_addr_sel = 1'b1;
            end
            S_BRANCH: begin
                o.alu_src_a = 2'd1;
                o.alu_op    = 2'b01;
                o.pc_src    = 1'b1;
            end
            S_JAL: begin
                o.reg_we = 1'b1;
                o.wb_sel = 2'd2;
                o.pc_src = 1'b1;
            end
            S_LUI: begin
                o.reg_we = 1'b1;
                o.wb_sel = 2'd3;
            end
            S_TRAP: begin
                o.illegal = 1'b1;
            end
            default: begin
                o = '0;
            end
        endcase
        return o;
    endfunction

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH:          state_d = (func3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
                    OP_JAL:             state_d = S_JAL;
                    OP_LUI:             state_d = S_LUI;
                    default:            state_d = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_MEM_ADDR:         state_d = opcode[5] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WR: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL, S_LUI: state_d = S_FETCH;
            S_TRAP:             state_d = S_TRAP;
            default:            state_d = S_TRAP;
        endcase
    end

    // Preload FETCH outputs under reset so the first cycle after release already requests
    always_comb begin
        moore_d = decode_outputs(reset ? S_FETCH : state_d, func3);
    end

    // State and registered Moore outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
        moore_q <= moore_d;
    end

    // Reset forces every output low in the same cycle, abandoning any request
    assign mem_req      = moore_q.mem_req      & ~reset;
    assign mem_we       = moore_q.mem_we       & ~reset;
    assign mem_addr_sel = moore_q.mem_addr_sel & ~reset;
    assign pc_src       = moore_q.pc_src       & ~reset;
    assign alu_src_a    = moore_q.alu_src_a    & {2{~reset}};
    assign alu_src_b    = moore_q.alu_src_b    & {2{~reset}};
    assign ALUOp        = moore_q.alu_op       & {2{~reset}};
    assign alu_func7_en = moore_q.alu_func7_en & ~reset;
    assign reg_we       = moore_q.reg_we       & ~reset;
    assign wb_sel       = moore_q.wb_sel       & {2{~reset}};
    assign illegal      = moore_q.illegal      & ~reset;

    // Handshake/condition-dependent strobes
    assign ir_we = ~reset & (state_q == S_FETCH) & mem_ready;
    assign pc_we = ~reset & (((state_q == S_FETCH) & mem_ready)
                           | ((state_q == S_BRANCH) & (alu_zero ^ func3[0]))
                           | (state_q == S_JAL));

endmodule
